// File: rtl/fp_addsub_pipe_fsm.sv
// Multi-cycle IEEE-754-style adder/subtractor: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Round-to-nearest-even, denormals flushed to zero, specials resolved during ALIGN.
module fp_addsub_pipe_fsm #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         flag_ovf,
    output logic         flag_uf,
    output logic         flag_inv
);
    localparam int SW   = MAN_W + 4;            // hidden + frac + G/R/S
    localparam int XW   = EXP_W + 2;            // signed exponent with head-room
    localparam int LZ_W = $clog2(MAN_W + 5);
    localparam logic signed [XW-1:0] EXP_TOP = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

    function automatic logic [LZ_W-1:0] f_lzc(input logic [SW-1:0] v);
        f_lzc = '0;
        for (int i = 0; i < SW; i++)
            if (v[i]) f_lzc = LZ_W'(SW - 1 - i);
    endfunction

    function automatic logic f_round_up(input logic lsb, input logic g, input logic r, input logic s);
        f_round_up = g & (r | s | lsb);
    endfunction

    state_t                 r_state;
    logic                   r_in_ready, r_out_valid, r_ovf, r_uf, r_inv;
    logic [W-1:0]           r_result, r_a, r_b, r_spec_res;
    logic                   r_sign, r_esub, r_spec, r_spec_inv, r_nzero;
    logic [EXP_W-1:0]       r_exp;
    logic [SW-1:0]          r_ma, r_mb, r_nsig;
    logic [SW:0]            r_sum;
    logic signed [XW-1:0]   r_nexp;

    // ALIGN: unpack, order by magnitude, shift the smaller operand with sticky collection
    logic                   w_sa, w_sb, w_za, w_zb, w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic [EXP_W-1:0]       w_ea, w_eb, w_ehi, w_elo, w_ed;
    logic [MAN_W-1:0]       w_fa, w_fb, w_fhi, w_flo;
    logic [W-2:0]           w_key_a, w_key_b;
    logic                   w_swap, w_zhi, w_zlo, w_shi;
    logic [SW-1:0]          w_mhi, w_mlo, w_mask, w_mlo_al;
    logic                   w_spec, w_spec_inv;
    logic [W-1:0]           w_spec_res;

    assign w_sa    = r_a[W-1];
    assign w_sb    = r_b[W-1];
    assign w_ea    = r_a[W-2:MAN_W];
    assign w_eb    = r_b[W-2:MAN_W];
    assign w_fa    = r_a[MAN_W-1:0];
    assign w_fb    = r_b[MAN_W-1:0];
    assign w_za    = (w_ea == '0);
    assign w_zb    = (w_eb == '0);
    assign w_nan_a = (&w_ea) & (|w_fa);
    assign w_nan_b = (&w_eb) & (|w_fb);
    assign w_inf_a = (&w_ea) & ~(|w_fa);
    assign w_inf_b = (&w_eb) & ~(|w_fb);
    assign w_key_a = w_za ? '0 : r_a[W-2:0];
    assign w_key_b = w_zb ? '0 : r_b[W-2:0];
    assign w_swap  = (w_key_b > w_key_a);
    assign w_ehi   = w_swap ? w_eb : w_ea;
    assign w_elo   = w_swap ? w_ea : w_eb;
    assign w_fhi   = w_swap ? w_fb : w_fa;
    assign w_flo   = w_swap ? w_fa : w_fb;
    assign w_zhi   = w_swap ? w_zb : w_za;
    assign w_zlo   = w_swap ? w_za : w_zb;
    assign w_shi   = w_swap ? w_sb : w_sa;
    assign w_mhi   = w_zhi ? '0 : {1'b1, w_fhi, 3'b000};
    assign w_mlo   = w_zlo ? '0 : {1'b1, w_flo, 3'b000};
    assign w_ed    = w_ehi - w_elo;
    assign w_mask  = ~({SW{1'b1}} << w_ed);
    assign w_mlo_al = (32'(w_ed) >= 32'(SW - 1)) ? {{(SW-1){1'b0}}, |w_mlo}
                    : ((w_mlo >> w_ed) | {{(SW-1){1'b0}}, |(w_mlo & w_mask)});

    always_comb begin
        w_spec     = 1'b1;
        w_spec_inv = 1'b0;
        w_spec_res = '0;
        if (w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (w_sa ^ w_sb))) begin
            w_spec_res = QNAN;
            w_spec_inv = 1'b1;
        end else if (w_inf_a) begin
            w_spec_res = r_a;
        end else if (w_inf_b) begin
            w_spec_res = r_b;
        end else if (w_za & w_zb) begin
            // both zero: only -0 + -0 keeps the negative sign
            w_spec_res = {w_sa & w_sb, {(W-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    // ADD / NORM datapath
    logic [SW:0]            w_sum;
    logic [LZ_W-1:0]        w_lzc;
    logic signed [XW-1:0]   w_exp_x;

    assign w_sum   = r_esub ? ({1'b0, r_ma} - {1'b0, r_mb}) : ({1'b0, r_ma} + {1'b0, r_mb});
    assign w_lzc   = f_lzc(r_sum[SW-1:0]);
    assign w_exp_x = $signed({2'b00, r_exp});

    // ROUND: nearest-even, carry-out renormalises by one
    logic                   w_up, w_rovf, w_ruf;
    logic [MAN_W+1:0]       w_rsig;
    logic signed [XW-1:0]   w_rexp;
    logic [MAN_W-1:0]       w_rfrac;

    assign w_up    = f_round_up(r_nsig[3], r_nsig[2], r_nsig[1], r_nsig[0]);
    assign w_rsig  = {1'b0, r_nsig[SW-1:3]} + {{(MAN_W+1){1'b0}}, w_up};
    assign w_rexp  = r_nexp + $signed({{(XW-1){1'b0}}, w_rsig[MAN_W+1]});
    assign w_rfrac = w_rsig[MAN_W+1] ? w_rsig[MAN_W:1] : w_rsig[MAN_W-1:0];
    assign w_rovf  = (w_rexp >= EXP_TOP);
    assign w_ruf   = (w_rexp <= $signed(XW'(0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_uf        <= 1'b0;
            r_inv       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= {b[W-1] ^ op_sub, b[W-2:0]};
                        r_ovf      <= 1'b0;
                        r_uf       <= 1'b0;
                        r_inv      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_sign     <= w_shi;
                    r_exp      <= w_ehi;
                    r_ma       <= w_mhi;
                    r_mb       <= w_mlo_al;
                    r_esub     <= w_sa ^ w_sb;
                    r_spec     <= w_spec;
                    r_spec_res <= w_spec_res;
                    r_spec_inv <= w_spec_inv;
                    r_state    <= S_ADD;
                end
                S_ADD: begin
                    r_sum   <= w_sum;
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_nzero <= (r_sum == '0);
                    if (r_sum[SW]) begin
                        r_nsig <= {r_sum[SW:2], r_sum[1] | r_sum[0]};
                        r_nexp <= w_exp_x + $signed(XW'(1));
                    end else begin
                        r_nsig <= r_sum[SW-1:0] << w_lzc;
                        r_nexp <= w_exp_x - $signed({{(XW-LZ_W){1'b0}}, w_lzc});
                    end
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    if (r_spec) begin
                        r_result <= r_spec_res;
                        r_inv    <= r_spec_inv;
                    end else if (r_nzero) begin
                        r_result <= '0;
                    end else if (w_rovf) begin
                        r_result <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        r_ovf    <= 1'b1;
                    end else if (w_ruf) begin
                        r_result <= {r_sign, {(W-1){1'b0}}};
                        r_uf     <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_rexp[EXP_W-1:0], w_rfrac};
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_ovf  = r_ovf;
    assign flag_uf   = r_uf;
    assign flag_inv  = r_inv;
endmodule
